// File: rtl/maze_pkg.sv
// Maze encodings shared by the BFS distance and backtrack stages, so both sides
// agree on direction order, cell addressing and the unreached-distance marker.
package maze_pkg;

    typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_GOAL, ST_CHK_GOAL, ST_EMIT, ST_PROBE, ST_CMP, ST_FIN
    } bt_state_t;

    typedef struct packed {
        logic valid;
        int   x;
        int   y;
    } nbr_t;

    // All-ones distance marks a cell the BFS never reached.
    function automatic int dist_inf(input int dw);
        return (1 << dw) - 1;
    endfunction

    function automatic int cell_addr(input int x, input int y, input int w);
        return y * w + x;
    endfunction

    // Bounds are judged on coordinates so an edge cell never wraps to the next row.
    function automatic nbr_t nbr(input int x, input int y, input dir_t dir,
                                 input int w, input int h);
        nbr_t n;
        n.x = x;
        n.y = y;
        case (dir)
            DIR_N:   n.y = y - 1;
            DIR_E:   n.x = x + 1;
            DIR_S:   n.y = y + 1;
            default: n.x = x - 1;
        endcase
        n.valid = (n.x >= 0) && (n.x < w) && (n.y >= 0) && (n.y < h);
        return n;
    endfunction

endpackage

// File: rtl/maze_nbr_gen.sv
// Combinational neighbour generator: coordinates and in-bounds flag for all four
// directions of one cell, indexed by dir_t.
module maze_nbr_gen
    import maze_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
) (
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    output logic [3:0]           nbr_valid,
    output logic [3:0][XW-1:0]   nbr_x,
    output logic [3:0][YW-1:0]   nbr_y
);

    always_comb begin
        nbr_t n;
        n         = '0;
        nbr_valid = '0;
        nbr_x     = '0;
        nbr_y     = '0;
        for (int d = 0; d < 4; d++) begin
            n            = nbr(int'(x), int'(y), dir_t'(d), W, H);
            nbr_valid[d] = n.valid;
            nbr_x[d]     = XW'(n.x);
            nbr_y[d]     = YW'(n.y);
        end
    end

endmodule

// File: rtl/bfs_backtrack.sv
// Backtrack engine: walks the BFS distance map from goal to start, writing each
// visited cell to the path RAM (goal at index 0).
module bfs_backtrack
    import maze_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H),
    parameter int AW = $clog2(W*H),
    parameter int DW = $clog2(W*H) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bt_en,
    input  logic [XW-1:0] start_x,
    input  logic [YW-1:0] start_y,
    input  logic [XW-1:0] goal_x,
    input  logic [YW-1:0] goal_y,
    output logic          dist_rd_en,
    output logic [AW-1:0] dist_rd_addr,
    input  logic [DW-1:0] dist_rd_data,
    output logic          path_we,
    output logic [AW-1:0] path_waddr,
    output logic [AW-1:0] path_wdata,
    output logic [AW:0]   path_len,
    output logic          busy,
    output logic          bt_done,
    output logic          bt_no_path,
    output bt_state_t     dbg_state
);

    localparam logic [DW-1:0] INF   = DW'(dist_inf(DW));
    localparam logic [AW:0]   CELLS = (AW+1)'(W*H);

    bt_state_t     state;
    logic          bt_en_q;
    logic [XW-1:0] sx, cur_x;
    logic [YW-1:0] sy, cur_y;
    logic [DW-1:0] cur_d;
    logic [AW:0]   idx;
    dir_t          cur_dir;

    logic [3:0]         nbr_valid;
    logic [3:0][XW-1:0] nbr_x;
    logic [3:0][YW-1:0] nbr_y;

    maze_nbr_gen #(.W(W), .H(H), .XW(XW), .YW(YW)) u_nbr (
        .x         (cur_x),
        .y         (cur_y),
        .nbr_valid (nbr_valid),
        .nbr_x     (nbr_x),
        .nbr_y     (nbr_y)
    );

    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(cell_addr(int'(x), int'(y), W));
    endfunction

    // First in-bounds direction from N, and first one after the direction just probed.
    // The probe read is registered one cycle ahead so PROBE carries the strobe itself.
    logic emit_hit, next_hit;
    dir_t emit_dir, next_dir;

    always_comb begin
        emit_hit = 1'b0;
        emit_dir = DIR_N;
        next_hit = 1'b0;
        next_dir = DIR_N;
        for (int d = 3; d >= 0; d--) begin
            if (nbr_valid[d]) begin
                emit_hit = 1'b1;
                emit_dir = dir_t'(d);
            end
            if (nbr_valid[d] && d > int'(cur_dir)) begin
                next_hit = 1'b1;
                next_dir = dir_t'(d);
            end
        end
    end

    logic at_start, cmp_hit, abort, fin_req, fin_np;

    assign at_start = (cur_x == sx) && (cur_y == sy);
    assign cmp_hit  = (dist_rd_data != INF) && (dist_rd_data == cur_d - DW'(1));
    assign abort    = (state != ST_IDLE) && (state != ST_FIN) && !bt_en;

    always_comb begin
        fin_req = 1'b0;
        fin_np  = 1'b0;
        case (state)
            ST_CHK_GOAL: if (dist_rd_data == INF) begin
                fin_req = 1'b1;
                fin_np  = 1'b1;
            end
            ST_EMIT: if (cur_d == '0) begin
                fin_req = 1'b1;
                fin_np  = !at_start;
            end else if (idx == CELLS) begin
                fin_req = 1'b1;
                fin_np  = 1'b1;
            end
            ST_PROBE: if (!dist_rd_en) begin
                fin_req = 1'b1;
                fin_np  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bt_en_q      <= 1'b0;
            sx           <= '0;
            sy           <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            cur_d        <= '0;
            idx          <= '0;
            cur_dir      <= DIR_N;
            dist_rd_en   <= 1'b0;
            dist_rd_addr <= '0;
            path_we      <= 1'b0;
            path_waddr   <= '0;
            path_wdata   <= '0;
            path_len     <= '0;
            busy         <= 1'b0;
            bt_done      <= 1'b0;
            bt_no_path   <= 1'b0;
        end else begin
            bt_en_q    <= bt_en;
            dist_rd_en <= 1'b0;
            path_we    <= 1'b0;
            bt_done    <= 1'b0;
            bt_no_path <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (fin_req) begin
                bt_done    <= 1'b1;
                bt_no_path <= fin_np;
                path_len   <= idx;
                state      <= ST_FIN;
            end else begin
                case (state)
                    ST_IDLE: if (bt_en && !bt_en_q) begin
                        sx           <= start_x;
                        sy           <= start_y;
                        cur_x        <= goal_x;
                        cur_y        <= goal_y;
                        idx          <= '0;
                        dist_rd_en   <= 1'b1;
                        dist_rd_addr <= addr_of(goal_x, goal_y);
                        busy         <= 1'b1;
                        state        <= ST_RD_GOAL;
                    end
                    ST_RD_GOAL: state <= ST_CHK_GOAL;
                    ST_CHK_GOAL: begin
                        cur_d      <= dist_rd_data;
                        path_we    <= 1'b1;
                        path_waddr <= idx[AW-1:0];
                        path_wdata <= addr_of(cur_x, cur_y);
                        idx        <= idx + 1'b1;
                        state      <= ST_EMIT;
                    end
                    ST_EMIT: begin
                        dist_rd_en   <= emit_hit;
                        dist_rd_addr <= addr_of(nbr_x[emit_dir], nbr_y[emit_dir]);
                        cur_dir      <= emit_dir;
                        state        <= ST_PROBE;
                    end
                    ST_PROBE: state <= ST_CMP;
                    ST_CMP: if (cmp_hit) begin
                        cur_x      <= nbr_x[cur_dir];
                        cur_y      <= nbr_y[cur_dir];
                        cur_d      <= dist_rd_data;
                        path_we    <= 1'b1;
                        path_waddr <= idx[AW-1:0];
                        path_wdata <= addr_of(nbr_x[cur_dir], nbr_y[cur_dir]);
                        idx        <= idx + 1'b1;
                        state      <= ST_EMIT;
                    end else begin
                        dist_rd_en   <= next_hit;
                        dist_rd_addr <= addr_of(nbr_x[next_dir], nbr_y[next_dir]);
                        cur_dir      <= next_dir;
                        state        <= ST_PROBE;
                    end
                    ST_FIN: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bfs_backtrack.sv
// Directed bench for bfs_backtrack on a 4x4 maze with a scoreboard of expected
// distance reads, path writes and completion results.
module tb_bfs_backtrack;
    import maze_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int AW = 4;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bt_en = 1'b0;
    logic [XW-1:0] start_x = '0, goal_x = '0;
    logic [YW-1:0] start_y = '0, goal_y = '0;
    logic          dist_rd_en;
    logic [AW-1:0] dist_rd_addr;
    logic [DW-1:0] dist_rd_data = '0;
    logic          path_we;
    logic [AW-1:0] path_waddr, path_wdata;
    logic [AW:0]   path_len;
    logic          busy, bt_done, bt_no_path;
    bt_state_t     dbg_state;

    always #5 clk = ~clk;

    bfs_backtrack #(.W(W), .H(H)) dut (
        .clk(clk), .rst(rst), .bt_en(bt_en),
        .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
        .dist_rd_en(dist_rd_en), .dist_rd_addr(dist_rd_addr), .dist_rd_data(dist_rd_data),
        .path_we(path_we), .path_waddr(path_waddr), .path_wdata(path_wdata),
        .path_len(path_len), .busy(busy), .bt_done(bt_done), .bt_no_path(bt_no_path),
        .dbg_state(dbg_state)
    );

    // Distance RAM: registered read, data valid the cycle after the strobe.
    logic [DW-1:0] dist_mem [W*H];
    always @(posedge clk) if (dist_rd_en) dist_rd_data <= dist_mem[dist_rd_addr];

    logic [AW-1:0]   exp_rd[$];
    logic [2*AW-1:0] exp_wr[$];
    logic [AW+1:0]   exp_done[$];
    logic [2*AW-1:0] mon_w;
    logic [AW+1:0]   mon_d;
    int vectors = 0, miscompares = 0;
    int done_seen = 0, wr_seen = 0, exp_idx = 0;
    int base_w, base_d;
    logic ignore_io = 1'b0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic er(input int a); exp_rd.push_back(AW'(a)); endtask
    task automatic ew(input int a);
        exp_wr.push_back({AW'(exp_idx), AW'(a)});
        exp_idx++;
    endtask
    task automatic ed(input int np, input int len);
        exp_done.push_back({1'(np), (AW+1)'(len)});
        exp_idx = 0;
    endtask

    // Open grid: BFS distance from (0,0) is x+y.
    task automatic load_open();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                dist_mem[y*W + x] = DW'(x + y);
    endtask

    function automatic int outs_flat();
        return int'({dist_rd_en, dist_rd_addr, path_we, path_waddr, path_wdata,
                     path_len, busy, bt_done, bt_no_path});
    endfunction

    task automatic run_walk(input int sx, input int sy, input int gx, input int gy);
        int d0;
        d0 = done_seen;
        start_x = XW'(sx); start_y = YW'(sy);
        goal_x  = XW'(gx); goal_y  = YW'(gy);
        @(posedge clk); #1 bt_en = 1'b1;
        for (int i = 0; i < 200 && done_seen == d0; i++) @(negedge clk);
        check("done_pulse", done_seen - d0, 1);
        repeat (20) @(negedge clk);
        check("no_rewalk", done_seen - d0, 1);
        check("rd_left", exp_rd.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("done_left", exp_done.size(), 0);
        @(posedge clk); #1 bt_en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, write or done.
    always @(negedge clk) begin
        if (!rst) begin
            if (dist_rd_en && !ignore_io) begin
                if (exp_rd.size() == 0) check("rd_unexpected", int'(dist_rd_addr), -1);
                else check("rd_addr", int'(dist_rd_addr), int'(exp_rd.pop_front()));
            end
            if (path_we) begin
                wr_seen++;
                if (!ignore_io) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", int'(path_wdata), -1);
                    else begin
                        mon_w = exp_wr.pop_front();
                        check("wr_idx", int'(path_waddr), int'(mon_w[2*AW-1:AW]));
                        check("wr_addr", int'(path_wdata), int'(mon_w[AW-1:0]));
                    end
                end
            end
            if (bt_done) begin
                done_seen++;
                if (exp_done.size() == 0) check("done_unexpected", int'(bt_done), 0);
                else begin
                    mon_d = exp_done.pop_front();
                    check("no_path", int'(bt_no_path), int'(mon_d[AW+1]));
                    check("path_len", int'(path_len), int'(mon_d[AW:0]));
                end
            end
            if (bt_no_path && !bt_done) check("no_path_outside_done", int'(bt_no_path), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        load_open();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_flat(), 0);
        check("reset_state", int'(dbg_state), int'(ST_IDLE));
        rst = 1'b0;

        // Open grid goal (3,3) -> start (0,0); corner (3,0) must skip N and E.
        er(15); er(11); er(7); er(3); er(7); er(2); er(3); er(6); er(1); er(2); er(5); er(0);
        ew(15); ew(11); ew(7); ew(3); ew(2); ew(1); ew(0); ed(0, 7);
        run_walk(0, 0, 3, 3);

        // Unreached goal.
        dist_mem[15] = 5'h1f;
        er(15); ed(1, 0);
        run_walk(0, 0, 3, 3);
        load_open();

        // start == goal.
        dist_mem[6] = '0;
        er(6); ew(6); ed(0, 1);
        run_walk(2, 1, 2, 1);
        load_open();

        // Tie at (1,1): N and W both distance 1, N wins.
        er(5); er(1); er(2); er(5); er(0);
        ew(5); ew(1); ew(0); ed(0, 3);
        run_walk(0, 0, 1, 1);

        // Corrupt map: no neighbour at d-1.
        dist_mem[1] = 5'd9; dist_mem[4] = 5'd9;
        er(5); er(1); er(6); er(9); er(4);
        ew(5); ed(1, 1);
        run_walk(0, 0, 1, 1);
        load_open();

        // Distance 0 reached at a cell that is not the start.
        er(1); er(2); er(5); er(0);
        ew(1); ew(0); ed(1, 2);
        run_walk(3, 3, 1, 0);

        // Abort by dropping bt_en after the third write.
        ignore_io = 1'b1;
        base_d = done_seen; base_w = wr_seen;
        start_x = 2'd0; start_y = 2'd0; goal_x = 2'd3; goal_y = 2'd3;
        @(posedge clk); #1 bt_en = 1'b1;
        for (int i = 0; i < 100 && wr_seen < base_w + 3; i++) @(negedge clk);
        check("abort_reach_step3", wr_seen - base_w, 3);
        @(posedge clk); #1 bt_en = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_state", int'(dbg_state), int'(ST_IDLE));
        check("abort_no_done", done_seen - base_d, 0);

        // Reset pulsed mid-walk.
        base_d = done_seen; base_w = wr_seen;
        @(posedge clk); #1 bt_en = 1'b1;
        for (int i = 0; i < 100 && wr_seen < base_w + 2; i++) @(negedge clk);
        check("rst_mid_reach", wr_seen - base_w, 2);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", outs_flat(), 0);
        check("rst_mid_state", int'(dbg_state), int'(ST_IDLE));
        bt_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_no_done", done_seen - base_d, 0);
        ignore_io = 1'b0;

        // A fresh rise completes normally.
        er(15); er(11); er(7); er(3); er(7); er(2); er(3); er(6); er(1); er(2); er(5); er(0);
        ew(15); ew(11); ew(7); ew(3); ew(2); ew(1); ew(0); ed(0, 7);
        run_walk(0, 0, 3, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
